// File: rtl/game_pkg.sv
// Shared definitions for the jump game: scheduler FSM states, pixel colours and
// the geometry of the wall field and the dude sprite.
package game_pkg;

  localparam int FIELD_W = 120;
  localparam int FIELD_H = 100;
  localparam int X_OFF   = 20;
  localparam int Y_OFF   = 10;
  localparam int SPR_W   = 4;
  localparam int SPR_H   = 6;

  localparam logic [2:0] COL_WALL  = 3'b111;
  localparam logic [2:0] COL_EMPTY = 3'b000;
  localparam logic [2:0] COL_DUDE  = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_STEP      = 3'd1,
    S_WALL_ADDR = 3'd2,
    S_WALL_CAP  = 3'd3,
    S_WALL_PX   = 3'd4,
    S_SPR       = 3'd5,
    S_DONE      = 3'd6
  } sched_state_e;

endpackage

// File: rtl/frame_scheduler_if.sv
// Scheduler-side bundle: datapath step handshake, wall store read port, sprite
// position, VGA pixel-write port and status. FRAME_SCHED_OVERRUN_CNT_EN adds overruns.
interface frame_scheduler_if;
  import game_pkg::*;

  // step_req is raised by the scheduler and held until step_ack is sampled high
  // on a rising clk edge; step_req drops the cycle after. step_ack may stall forever.
  logic               step_req;
  logic               step_ack;
  logic [6:0]         wall_rd_col;
  logic [FIELD_H-1:0] wall_rd_data;
  logic [6:0]         spr_x;
  logic [7:0]         spr_y;
  logic               plot;
  logic [7:0]         x;
  logic [6:0]         y;
  logic [2:0]         colour;
  logic               frame_done;
  logic               busy;
  sched_state_e       dbg_state;
`ifdef FRAME_SCHED_OVERRUN_CNT_EN
  logic [7:0]         overruns;
`endif

  modport master (
    output step_req, wall_rd_col, plot, x, y, colour, frame_done, busy, dbg_state,
`ifdef FRAME_SCHED_OVERRUN_CNT_EN
    output overruns,
`endif
    input  step_ack, wall_rd_data, spr_x, spr_y
  );

  modport slave (
    input  step_req, wall_rd_col, plot, x, y, colour, frame_done, busy, dbg_state,
`ifdef FRAME_SCHED_OVERRUN_CNT_EN
    input  overruns,
`endif
    output step_ack, wall_rd_data, spr_x, spr_y
  );

endinterface

// File: rtl/frame_scheduler_tick_divider.sv
// Game tick generator: counts 0..TICK_DIV-1 while enabled, pulses tick on the
// wrap cycle, and holds at zero while disabled.
module tick_divider #(
  parameter int unsigned TICK_DIV = 833333
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic tick
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = en && (cnt_q == LAST);
    cnt_d = cnt_q + 1'b1;
    if (!en || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/frame_scheduler.sv
// Game-tick / redraw sequencer: one datapath step per tick, then a column-wise wall
// redraw plus sprite. FRAME_SCHED_OVERRUN_CNT_EN adds a saturating dropped-tick count.
module frame_scheduler
  import game_pkg::*;
#(
  parameter int unsigned TICK_DIV = 833333
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ingame,
  frame_scheduler_if.master sched
);
  sched_state_e       state_q, state_d;
  logic [6:0]         col_q, col_d, row_q, row_d;
  logic [2:0]         i_q, i_d, j_q, j_d;
  logic [6:0]         sx_q, sx_d;
  logic [7:0]         sy_q, sy_d;
  logic [FIELD_H-1:0] buf_q, buf_d;
  logic               tick, row_last, col_last, spr_last;
  logic [8:0]         fld_x, fld_y, sum_x, sum_y;
  logic               step_req, plot, frame_done;
  logic [6:0]         wall_rd_col;
  logic [2:0]         colour;

  tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk(clk), .reset_n(reset_n), .en(ingame), .tick(tick)
  );

  assign row_last = (row_q == 7'(FIELD_H - 1));
  assign col_last = (col_q == 7'(FIELD_W - 1));
  assign spr_last = (i_q == 3'(SPR_W - 1)) && (j_q == 3'(SPR_H - 1));
  assign fld_x    = 9'(sx_q) + 9'(i_q);
  assign fld_y    = 9'(sy_q) + 9'(j_q);

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Ticks arriving outside IDLE are simply lost; ingame low wins over everything.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (tick) state_d = S_STEP;
      S_STEP:      if (sched.step_ack) state_d = S_WALL_ADDR;
      S_WALL_ADDR: state_d = S_WALL_CAP;
      S_WALL_CAP:  state_d = S_WALL_PX;
      S_WALL_PX:   if (row_last) state_d = col_last ? S_SPR : S_WALL_ADDR;
      S_SPR:       if (spr_last) state_d = S_DONE;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
    if (!ingame) state_d = S_IDLE;
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    i_d   = i_q;
    j_d   = j_q;
    sx_d  = sx_q;
    sy_d  = sy_q;
    buf_d = buf_q;
    case (state_q)
      S_STEP: if (sched.step_ack) begin
        sx_d  = sched.spr_x;
        sy_d  = sched.spr_y;
        col_d = '0;
      end
      S_WALL_CAP: begin
        buf_d = sched.wall_rd_data;
        row_d = '0;
      end
      S_WALL_PX: begin
        if (!row_last)     row_d = row_q + 7'd1;
        else if (col_last) begin
          i_d = '0;
          j_d = '0;
        end else           col_d = col_q + 7'd1;
      end
      S_SPR: begin
        if (j_q == 3'(SPR_H - 1)) begin
          j_d = '0;
          i_d = i_q + 3'd1;
        end else j_d = j_q + 3'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      col_q <= '0;
      row_q <= '0;
      i_q   <= '0;
      j_q   <= '0;
      sx_q  <= '0;
      sy_q  <= '0;
      buf_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      i_q   <= i_d;
      j_q   <= j_d;
      sx_q  <= sx_d;
      sy_q  <= sy_d;
      buf_q <= buf_d;
    end
  end

  // Sprite pixels outside the field still take their cycle, only plot is masked.
  always_comb begin
    step_req    = 1'b0;
    plot        = 1'b0;
    frame_done  = 1'b0;
    wall_rd_col = '0;
    colour      = COL_EMPTY;
    sum_x       = '0;
    sum_y       = '0;
    case (state_q)
      S_STEP:      step_req    = 1'b1;
      S_WALL_ADDR: wall_rd_col = col_q;
      S_WALL_PX: begin
        plot   = 1'b1;
        sum_x  = 9'(X_OFF) + 9'(col_q);
        sum_y  = 9'(Y_OFF) + 9'(row_q);
        colour = buf_q[row_q] ? COL_WALL : COL_EMPTY;
      end
      S_SPR: begin
        plot   = (fld_x < 9'(FIELD_W)) && (fld_y < 9'(FIELD_H));
        sum_x  = 9'(X_OFF) + fld_x;
        sum_y  = 9'(Y_OFF) + fld_y;
        colour = COL_DUDE;
      end
      S_DONE:      frame_done  = 1'b1;
      default: ;
    endcase
  end

  assign sched.step_req    = step_req;
  assign sched.plot        = plot;
  assign sched.x           = sum_x[7:0];
  assign sched.y           = sum_y[6:0];
  assign sched.colour      = colour;
  assign sched.wall_rd_col = wall_rd_col;
  assign sched.frame_done  = frame_done;
  assign sched.busy        = (state_q != S_IDLE);
  assign sched.dbg_state   = state_q;

`ifdef FRAME_SCHED_OVERRUN_CNT_EN
  logic [7:0] ovr_q, ovr_d;

  always_comb begin
    ovr_d = ovr_q;
    if (!ingame) ovr_d = '0;
    else if (tick && (state_q != S_IDLE) && (ovr_q != 8'hFF)) ovr_d = ovr_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) ovr_q <= '0;
    else          ovr_q <= ovr_d;
  end

  assign sched.overruns = ovr_q;
`endif

endmodule

// File: tb/tb_frame_scheduler.sv
// Bench for frame_scheduler: a TICK_DIV=16000 instance for frame content/timing and
// aborts, and a TICK_DIV=8000 instance for dropped ticks.
`timescale 1ns/1ps
module tb_frame_scheduler;

  logic clk = 1'b0;
  logic reset_n;
  logic ingame;
  logic ingame_b;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   base = 0;
  bit   base_valid = 1'b0;
  bit   b_finished = 1'b0;
  int   pat_mode = 0;
  int   done_cnt_a = 0;
  int   plot_cnt = 0;
  int   spr_cnt = 0;
  logic [17:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  frame_scheduler_if u_if_a ();
  frame_scheduler_if u_if_b ();

  frame_scheduler #(.TICK_DIV(16000)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .ingame(ingame), .sched(u_if_a.master)
  );
  frame_scheduler #(.TICK_DIV(8000)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .ingame(ingame_b), .sched(u_if_b.master)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc - base);
    end
  endtask

  function automatic logic [99:0] wall_col(input logic [6:0] c);
    logic [99:0] v;
    v = 100'd1;
    if (pat_mode != 0) v[(int'(c) * 7 + 3) % 100] = 1'b1;
    return v;
  endfunction

  // Wall store: registered read, data valid the cycle after the address.
  always @(posedge clk) u_if_a.wall_rd_data <= wall_col(u_if_a.wall_rd_col);

  task automatic push_frame(input int sx, input int sy);
    logic [99:0] w;
    for (int c = 0; c < 120; c++) begin
      w = wall_col(7'(c));
      for (int r = 0; r < 100; r++)
        exp_q.push_back({8'(20 + c), 7'(10 + r), w[r] ? 3'b111 : 3'b000});
    end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 6; j++)
        if (sx + i < 120 && sy + j < 100)
          exp_q.push_back({8'(20 + sx + i), 7'(10 + sy + j), 3'b100});
  endtask

  always @(negedge clk) begin
    if (u_if_a.plot === 1'b1) begin
      plot_cnt++;
      if (u_if_a.colour === 3'b100) spr_cnt++;
      if (exp_q.size() == 0) check_eq("plot_unexpected", 1, 0);
      else check_eq("pixel", {u_if_a.x, u_if_a.y, u_if_a.colour}, exp_q.pop_front());
    end
    if (u_if_a.frame_done === 1'b1) done_cnt_a++;
  end

  task automatic check_quiet(input string tag);
    check_eq({tag, "_step_req"}, u_if_a.step_req, 0);
    check_eq({tag, "_plot"}, u_if_a.plot, 0);
    check_eq({tag, "_frame_done"}, u_if_a.frame_done, 0);
    check_eq({tag, "_busy"}, u_if_a.busy, 0);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Holds step_ack low for 'delay' cycles of step_req, then acks once.
  task automatic drive_ack(input int delay, input int exp_rise);
    int n;
    n = 0;
    while (u_if_a.step_req !== 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check_eq("step_req_rise_cyc", cyc - base, exp_rise - base);
    n = 0;
    while (u_if_a.step_req === 1'b1 && n < 200) begin
      n++;
      if (n > delay) u_if_a.step_ack = 1'b1;
      @(negedge clk);
    end
    u_if_a.step_ack = 1'b0;
    check_eq("step_req_len", n, delay + 1);
  endtask

  task automatic wait_done(input int exp_cyc);
    int n;
    n = 0;
    while (u_if_a.frame_done !== 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check_eq("frame_done_cyc", cyc - base, exp_cyc - base);
    check_eq("queue_empty", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    check_eq("frame_done_width", u_if_a.frame_done, 0);
    check_eq("idle_after_done", u_if_a.busy, 0);
  endtask

  initial begin
    int t;
    int d0;
    reset_n = 1'b0;
    ingame = 1'b0;
    ingame_b = 1'b0;
    u_if_a.step_ack = 1'b0;
    u_if_a.spr_x = '0;
    u_if_a.spr_y = '0;
    u_if_b.step_ack = 1'b1;
    u_if_b.spr_x = '0;
    u_if_b.spr_y = '0;
    u_if_b.wall_rd_data = '0;
    repeat (3) @(negedge clk);
    check_quiet("rst");
    check_eq("rst_x", u_if_a.x, 0);
    check_eq("rst_y", u_if_a.y, 0);
    check_eq("rst_colour", u_if_a.colour, 0);
    check_eq("rst_wall_rd_col", u_if_a.wall_rd_col, 0);

    // Frame 1: ack immediate, row 0 walls, sprite fully inside the field.
    ingame = 1'b1;
    ingame_b = 1'b1;
    pat_mode = 0;
    u_if_a.spr_x = 7'd20;
    u_if_a.spr_y = 8'd50;
    push_frame(20, 50);
    reset_n = 1'b1;
    base = cyc;
    base_valid = 1'b1;
    t = base + 15999;
    wait_cyc(t);
    check_quiet("pre_tick");
    plot_cnt = 0;
    spr_cnt = 0;
    drive_ack(0, t + 1);
    wait_done(t + 12266);
    check_eq("f1_plots", plot_cnt, 12024);
    check_eq("f1_spr_plots", spr_cnt, 24);

    // Frame 2: ack after 37 cycles, patterned walls, sprite clipped at the corner.
    pat_mode = 1;
    u_if_a.spr_x = 7'd118;
    u_if_a.spr_y = 8'd97;
    push_frame(118, 97);
    t = base + 31999;
    wait_cyc(t);
    check_quiet("f2_pre_tick");
    plot_cnt = 0;
    spr_cnt = 0;
    drive_ack(37, t + 1);
    wait_done(t + 12266 + 37);
    check_eq("f2_plots", plot_cnt, 12006);
    check_eq("f2_spr_plots", spr_cnt, 6);

    // Frame 3: reset while stalled in STEP.
    t = base + 47999;
    wait_cyc(t + 11);
    check_eq("stall_step_req", u_if_a.step_req, 1);
    d0 = done_cnt_a;
    reset_n = 1'b0;
    @(negedge clk);
    check_quiet("after_reset");
    reset_n = 1'b1;
    base = cyc;

    // Frame 4: ingame dropped in the middle of the wall pass.
    u_if_a.spr_x = 7'd5;
    u_if_a.spr_y = 8'd5;
    push_frame(5, 5);
    t = base + 15999;
    wait_cyc(t);
    check_quiet("f4_pre_tick");
    check_eq("no_done_after_reset", done_cnt_a, d0);
    drive_ack(0, t + 1);
    wait_cyc(t + 2 + 3 * 102 + 2 + 40);
    check_eq("plot_mid_wall", u_if_a.plot, 1);
    check_eq("y_mid_wall", u_if_a.y, 50);
    ingame = 1'b0;
    @(negedge clk);
    check_quiet("after_ingame_drop");
    exp_q.delete();
    repeat (200) @(negedge clk);
    check_eq("no_done_after_drop", done_cnt_a, d0);
    check_eq("idle_after_drop", u_if_a.busy, 0);

    while (!b_finished) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Second instance: a tick during a frame must be dropped, not queued.
  initial begin
    wait (base_valid);
    wait_cyc(base + 7999);
    check_eq("b_busy_pre_tick", u_if_b.busy, 0);
    @(negedge clk);
    check_eq("b_step1", u_if_b.step_req, 1);
    wait_cyc(base + 16100);
    check_eq("b_busy_over", u_if_b.busy, 1);
`ifdef FRAME_SCHED_OVERRUN_CNT_EN
    check_eq("b_overruns_1", u_if_b.overruns, 1);
`endif
    wait_cyc(base + 7999 + 12266);
    check_eq("b_done1", u_if_b.frame_done, 1);
    wait_cyc(base + 23999);
    check_eq("b_idle_before_tick3", u_if_b.busy, 0);
    check_eq("b_no_queued_step", u_if_b.step_req, 0);
    @(negedge clk);
    check_eq("b_step3", u_if_b.step_req, 1);
`ifdef FRAME_SCHED_OVERRUN_CNT_EN
    check_eq("b_overruns_hold", u_if_b.overruns, 1);
`endif
    ingame_b = 1'b0;
    @(negedge clk);
    check_eq("b_idle_after_drop", u_if_b.busy, 0);
`ifdef FRAME_SCHED_OVERRUN_CNT_EN
    check_eq("b_overruns_clear", u_if_b.overruns, 0);
`endif
    b_finished = 1'b1;
  end

endmodule
